note_decoder: RTL and testbench
===============================

# note_decoder

Inverse of the keyboard note encoder: accepts a 3-bit note code plus valid, maps it back through the same 24-bit key-to-code table to a key index, lights the matching key LED, and drives a square-wave buzzer at that key's pitch. It sits between the note source (live keyboard encoder or song playback) and the board LED/buzzer pins.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency; documents the tone constants, which are fixed for this value
- `SIM_FAST`, 0, when 1 the half-period for key i is (i+1)*4 cycles, for simulation
- `SUSTAIN_CYCLES`, 25_000_000, release sustain length (used only with the macro)

- `clk` in 1: system clock
- `rst_n` in 1: asynchronous, active-low reset
- `map` in 24: key-to-code table, `map[3*i +: 3]` = code of key i; same format the encoder uses
- `note_in` in 3: note code
- `note_valid` in 1: level; high = note held
- `key_led` out 8: one-hot lit key, 0 when silent
- `buzzer` out 1: square-wave tone
- `miss` out 1: high while a valid code matches no table entry
- `playing` out 1: high while the buzzer is active

## Operation
- Stage 1 registers `note_valid`, `note_in`, and `map`.
- Decode: key index = lowest i with `map[3*i +: 3]` == registered code; no match → miss.
- FSM states:
  - IDLE → PLAY when valid and hit.
  - IDLE/PLAY → MISS when valid and no hit.
  - MISS → PLAY on hit.
  - PLAY/MISS → IDLE when valid is low (or → SUSTAIN when the macro is defined).
- Outputs by state:
  - PLAY: `key_led` = 1 << idx; `playing` = 1.
  - MISS: `miss` = 1; `key_led` = 0; `playing` = 0.
  - IDLE: all outputs 0.
- Tone counter: 18-bit up-counter, runs only in PLAY/SUSTAIN.
  - When the count equals half[idx]-1: counter → 0 and `buzzer` toggles.
  - half[] for keys 0..7 (C4..C5): 191110, 170265, 151685, 143172, 127551, 113636, 101239, 95556.
- Note change while in PLAY (different idx): counter clears to 0, `buzzer` keeps its current level, `key_led` updates. There is no glitch pulse.
- Same code re-presented: the counter is not disturbed.
- Entering IDLE or MISS: `buzzer` forced 0 and counter cleared in the same cycle.
- Duplicate codes in `map`: the lowest key index wins, matching the encoder's priority.

## Timing
- Reset (async assert, sync release): state IDLE, counter 0; `key_led`=0, `buzzer`=0, `miss`=0, `playing`=0.
- Latency: `note_valid` edge at cycle n → `key_led`, `playing`, `miss` change at cycle n+2 (input register, then state register).
- First `buzzer` rising edge occurs half[idx] cycles after entering PLAY.
- Release: `buzzer` is 0 at n+2 after `note_valid` falls.
- Reset asserted mid-note: all outputs 0 immediately (asynchronous); restart is from IDLE.

## Configuration
- Macro: `NOTE_DECODER_SUSTAIN_EN`.
- Defined:
  - Valid falling in PLAY → SUSTAIN.
  - SUSTAIN keeps the last idx, tone, and LED for `SUSTAIN_CYCLES` cycles, then goes to IDLE.
  - A new valid hit during SUSTAIN → PLAY immediately; the sustain counter clears.
  - A valid miss during SUSTAIN → MISS.
- Undefined: no SUSTAIN state, no sustain counter; release goes directly to IDLE.

## Structure
- Shared package `piano_pkg`:
  - `NOTE_W`=3, `KEYS`=8
  - the half-period constant array
  - state enum (IDLE, PLAY, MISS, SUSTAIN)
  - the `map` slice helper width
- Sub-module `code_to_key`: combinational table search giving `idx[2:0]` and `hit`. The tone counter and FSM stay in the top.

## Test plan
1. Identity map `24'b111_110_101_100_011_010_001_000` (key i = code i), `SIM_FAST`=1; hold `note_in`=3 valid → `key_led`=8'b0000_1000 two cycles later; `buzzer` toggles every 16 cycles.
2. Switch `note_in` 3→0 mid-tone → counter restarts; next toggle 4 cycles after the change registers; `buzzer` level continuous; `key_led`=8'b0000_0001.
3. Map with key 2 and key 5 both = code 6, no entry for code 7; `note_in`=6 → `key_led`=8'b0000_0100. `note_in`=7 → `miss`=1, `key_led`=0, `buzzer`=0.
4. Drop `note_valid` → outputs 0 at n+2 (macro undefined). With macro defined and `SUSTAIN_CYCLES`=20: tone continues 20 cycles, then IDLE; re-press at cycle 10 → PLAY, no IDLE gap.
5. Assert `rst_n`=0 mid-tone, asynchronously between clock edges → all outputs 0 before the next edge; after release with valid still high → PLAY again at n+2.

Source files
------------

// File: rtl/piano_pkg.sv
// piano_pkg
// Shared definitions for the keyboard note path (encoder side and note_decoder).
//   NOTE_W / KEYS / MAP_W : note code width, key count, key-to-code table width
//   TONE_W                : width of the tone half-period counter
//   HALF_PERIOD           : buzzer half-period in cycles of a 100 MHz clock, keys C4..C5
//   KEY_CHZ               : key pitch in centi-hertz, used to derive half-periods
//                           when the clock is not 100 MHz
//   state_t               : note_decoder FSM states
//   mapSlice()            : extracts the code of one key from a packed table
package piano_pkg;

  localparam int NOTE_W = 3;
  localparam int KEYS   = 8;
  localparam int MAP_W  = NOTE_W * KEYS;
  localparam int TONE_W = 18;

  localparam logic [TONE_W-1:0] HALF_PERIOD [KEYS] = '{
    18'd191110, 18'd170265, 18'd151685, 18'd143172,
    18'd127551, 18'd113636, 18'd101239, 18'd95556
  };

  localparam int unsigned KEY_CHZ [KEYS] = '{
    26163, 29366, 32963, 34923, 39200, 44000, 49388, 52325
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    MISS    = 2'd2,
    SUSTAIN = 2'd3
  } state_t;

  function automatic logic [NOTE_W-1:0] mapSlice(input logic [MAP_W-1:0] tableBits,
                                                 input int key);
    return tableBits[NOTE_W*key +: NOTE_W];
  endfunction

  // Half-period for an arbitrary clock; results beyond TONE_W bits wrap,
  // so only clocks up to roughly 130 MHz give sensible tones.
  function automatic logic [TONE_W-1:0] halfForClock(input longint clkHz, input int key);
    longint half;
    half = (clkHz * 100) / (2 * longint'(KEY_CHZ[key]));
    return half[TONE_W-1:0];
  endfunction

endpackage

// File: rtl/code_to_key.sv
// code_to_key
// Combinational reverse lookup of a note code in the key-to-code table.
//   i_map  : packed table, i_map[3*i +: 3] = code of key i
//   i_code : code to search for
//   o_idx  : lowest key index whose entry equals i_code (0 when no hit)
//   o_hit  : 1 when at least one entry matches
module code_to_key
  import piano_pkg::*;
(
  input  logic [MAP_W-1:0]  i_map,
  input  logic [NOTE_W-1:0] i_code,
  output logic [2:0]        o_idx,
  output logic              o_hit
);

  // Scan from the top key downward so the lowest matching key is the last
  // one written, giving the same priority as the encoder on duplicate codes.
  always_comb begin
    o_idx = '0;
    o_hit = 1'b0;
    for (int i = KEYS - 1; i >= 0; i--) begin
      if (mapSlice(i_map, i) == i_code) begin
        o_idx = 3'(i);
        o_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/note_decoder.sv
// note_decoder
// Turns a note code back into a lit key LED and a square-wave buzzer tone.
// Parameters:
//   CLK_HZ         : system clock frequency; the stored tone table assumes 100 MHz
//   SIM_FAST       : 1 -> half-period of key i is (i+1)*4 cycles
//   SUSTAIN_CYCLES : release sustain length (only with NOTE_DECODER_SUSTAIN_EN)
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   map         : key-to-code table, map[3*i +: 3] = code of key i
//   note_in     : note code
//   note_valid  : level, high while a note is held
//   key_led     : one-hot lit key, 0 when silent
//   buzzer      : square-wave tone
//   miss        : high while a valid code matches no table entry
//   playing     : high while the buzzer is active
// Optional feature macro: NOTE_DECODER_SUSTAIN_EN adds a SUSTAIN state that keeps
// the last tone sounding for SUSTAIN_CYCLES cycles after release.
module note_decoder
  import piano_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SIM_FAST = 0
`ifdef NOTE_DECODER_SUSTAIN_EN
  , parameter int SUSTAIN_CYCLES = 25_000_000
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [MAP_W-1:0] map,
  input  logic [NOTE_W-1:0] note_in,
  input  logic             note_valid,
  output logic [KEYS-1:0]  key_led,
  output logic             buzzer,
  output logic             miss,
  output logic             playing
);

  localparam bit USE_TABLE = (CLK_HZ == 100_000_000);

  logic              r_valid;
  logic [NOTE_W-1:0] r_code;
  logic [MAP_W-1:0]  r_map;
  state_t            r_state;
  state_t            w_nextState;
  logic [2:0]        r_idx;
  logic [2:0]        w_idx;
  logic              w_hit;
  logic [TONE_W-1:0] r_toneCnt;
  logic              r_buzz;
  logic [TONE_W-1:0] w_halfTab [KEYS];
  logic [TONE_W-1:0] w_halfM1;
  logic              w_curActive;
  logic              w_nextActive;

  // Input stage: everything downstream works on registered copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_code  <= '0;
      r_map   <= '0;
    end else begin
      r_valid <= note_valid;
      r_code  <= note_in;
      r_map   <= map;
    end
  end

  code_to_key u_codeToKey (
    .i_map  (r_map),
    .i_code (r_code),
    .o_idx  (w_idx),
    .o_hit  (w_hit)
  );

  // Per-key half-periods resolved at elaboration time.
  for (genvar k = 0; k < KEYS; k++) begin : g_half
    if (SIM_FAST != 0) begin : g_fast
      assign w_halfTab[k] = TONE_W'((k + 1) * 4);
    end else if (USE_TABLE) begin : g_table
      assign w_halfTab[k] = HALF_PERIOD[k];
    end else begin : g_derived
      assign w_halfTab[k] = halfForClock(longint'(CLK_HZ), k);
    end
  end

  assign w_halfM1 = w_halfTab[r_idx] - TONE_W'(1);

`ifdef NOTE_DECODER_SUSTAIN_EN
  localparam int SUS_W = (SUSTAIN_CYCLES > 1) ? $clog2(SUSTAIN_CYCLES) : 1;
  logic [SUS_W-1:0] r_susCnt;
  logic             w_susDone;

  assign w_susDone = (r_susCnt == SUS_W'(SUSTAIN_CYCLES - 1));

  // Counts cycles spent in SUSTAIN; it is zero whenever SUSTAIN is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_susCnt <= '0;
    end else if (r_state == SUSTAIN && w_nextState == SUSTAIN) begin
      r_susCnt <= r_susCnt + SUS_W'(1);
    end else begin
      r_susCnt <= '0;
    end
  end
`endif

  // State register; the key index is captured whenever PLAY is (re)entered or held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_nextState == PLAY) begin
        r_idx <= w_idx;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE: begin
        if (r_valid) begin
          w_nextState = w_hit ? PLAY : MISS;
        end
      end
      PLAY: begin
        if (!r_valid) begin
`ifdef NOTE_DECODER_SUSTAIN_EN
          w_nextState = SUSTAIN;
`else
          w_nextState = IDLE;
`endif
        end else if (!w_hit) begin
          w_nextState = MISS;
        end
      end
      MISS: begin
        if (!r_valid) begin
          w_nextState = IDLE;
        end else if (w_hit) begin
          w_nextState = PLAY;
        end
      end
`ifdef NOTE_DECODER_SUSTAIN_EN
      SUSTAIN: begin
        if (r_valid) begin
          w_nextState = w_hit ? PLAY : MISS;
        end else if (w_susDone) begin
          w_nextState = IDLE;
        end
      end
`endif
      default: w_nextState = IDLE;
    endcase
  end

  assign w_curActive  = (r_state == PLAY) || (r_state == SUSTAIN);
  assign w_nextActive = (w_nextState == PLAY) || (w_nextState == SUSTAIN);

  // Tone generator. Going silent clears counter and buzzer together; a new
  // key restarts the count but leaves the buzzer level alone so the output
  // never produces a short glitch pulse at the note change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_toneCnt <= '0;
      r_buzz    <= 1'b0;
    end else if (!w_nextActive) begin
      r_toneCnt <= '0;
      r_buzz    <= 1'b0;
    end else if (!w_curActive || (w_nextState == PLAY && w_idx != r_idx)) begin
      r_toneCnt <= '0;
    end else if (r_toneCnt == w_halfM1) begin
      r_toneCnt <= '0;
      r_buzz    <= ~r_buzz;
    end else begin
      r_toneCnt <= r_toneCnt + TONE_W'(1);
    end
  end

  assign key_led = w_curActive ? (KEYS'(1) << r_idx) : '0;
  assign playing = w_curActive;
  assign miss    = (r_state == MISS);
  assign buzzer  = r_buzz;

endmodule

// File: tb/tb_note_decoder.sv
// tb_note_decoder
// Self-checking bench for note_decoder with SIM_FAST=1 (key i half-period (i+1)*4).
// The reference model tracks the sounding key, the miss flag and the tone
// phase origin; the buzzer level is derived arithmetically from the cycles
// elapsed since the current key started.
module tb_note_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] map = '0;
  logic [2:0]  note_in = '0;
  logic        note_valid = 1'b0;
  logic [7:0]  key_led;
  logic        buzzer;
  logic        miss;
  logic        playing;

`ifdef NOTE_DECODER_SUSTAIN_EN
  localparam bit SUS_EN  = 1'b1;
`else
  localparam bit SUS_EN  = 1'b0;
`endif
  localparam int SUS_LEN = 20;

  localparam logic [23:0] IDENTITY = 24'b111_110_101_100_011_010_001_000;
  // key2 and key5 both code 6, code 7 absent
  localparam logic [23:0] DUPMAP = {3'd2, 3'd5, 3'd6, 3'd4, 3'd3, 3'd6, 3'd1, 3'd0};

  note_decoder #(
    .CLK_HZ   (100_000_000),
    .SIM_FAST (1)
`ifdef NOTE_DECODER_SUSTAIN_EN
    , .SUSTAIN_CYCLES (SUS_LEN)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .map        (map),
    .note_in    (note_in),
    .note_valid (note_valid),
    .key_led    (key_led),
    .buzzer     (buzzer),
    .miss       (miss),
    .playing    (playing)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;

  // Reference model state
  int          cyc = 0;
  bit          pValid;
  logic [2:0]  pCode;
  logic [23:0] pMap;
  int          mKey;
  bit          mMiss;
  bit          mBase;
  int          mStart;
  int          mSus;

  function automatic int lowestKey(input logic [23:0] m, input logic [2:0] c);
    for (int i = 0; i < 8; i++) begin
      if (m[3*i +: 3] == c) return i;
    end
    return -1;
  endfunction

  function automatic bit buzzAt(input int t);
    int h;
    if (mKey < 0) return 1'b0;
    h = (mKey + 1) * 4;
    return mBase ^ bit'(((t - mStart) / h) % 2);
  endfunction

  task automatic modelReset();
    pValid = 1'b0;
    pCode  = '0;
    pMap   = '0;
    mKey   = -1;
    mMiss  = 1'b0;
    mBase  = 1'b0;
    mStart = 0;
    mSus   = -1;
  endtask

  // One clock edge of the behavioural model: decisions use the inputs
  // captured at the previous edge, then the current inputs are captured.
  task automatic modelEdge();
    int k;
    k = lowestKey(pMap, pCode);
    if (!pValid) begin
      mMiss = 1'b0;
      if (SUS_EN && mKey >= 0) begin
        mSus = (mSus < 0) ? 0 : mSus + 1;
        if (mSus == SUS_LEN) begin
          mKey = -1;
          mSus = -1;
        end
      end else begin
        mKey = -1;
        mSus = -1;
      end
    end else begin
      mSus = -1;
      if (k < 0) begin
        mKey  = -1;
        mMiss = 1'b1;
      end else begin
        if (k != mKey) begin
          mBase  = (mKey < 0) ? 1'b0 : buzzAt(cyc - 1);
          mStart = cyc;
          mKey   = k;
        end
        mMiss = 1'b0;
      end
    end
    pValid = note_valid;
    pCode  = note_in;
    pMap   = map;
  endtask

  task automatic checkOutput(input string tag);
    logic [7:0] expLed;
    logic       expBuzz;
    logic       expPlay;
    logic       expMiss;
    expLed  = (mKey >= 0) ? (8'd1 << mKey) : 8'd0;
    expPlay = (mKey >= 0);
    expMiss = mMiss;
    expBuzz = buzzAt(cyc);
    vectors++;
    assert (key_led === expLed) else begin
      fails++;
      $error("[TB] FAIL %s key_led cyc=%0d observed=%b expected=%b", tag, cyc, key_led, expLed);
    end
    vectors++;
    assert (playing === expPlay) else begin
      fails++;
      $error("[TB] FAIL %s playing cyc=%0d observed=%b expected=%b", tag, cyc, playing, expPlay);
    end
    vectors++;
    assert (miss === expMiss) else begin
      fails++;
      $error("[TB] FAIL %s miss cyc=%0d observed=%b expected=%b", tag, cyc, miss, expMiss);
    end
    vectors++;
    assert (buzzer === expBuzz) else begin
      fails++;
      $error("[TB] FAIL %s buzzer cyc=%0d observed=%b expected=%b", tag, cyc, buzzer, expBuzz);
    end
  endtask

  task automatic checkSilent(input string tag);
    vectors++;
    assert ({key_led, playing, miss, buzzer} === 11'd0) else begin
      fails++;
      $error("[TB] FAIL %s outputs observed=%b_%b_%b_%b expected=all zero",
             tag, key_led, playing, miss, buzzer);
    end
  endtask

  // Advance n clocks, checking every output after each edge.
  task automatic applyStimulus(input int n, input string tag);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      cyc++;
      modelEdge();
      checkOutput(tag);
    end
  endtask

  initial begin
    modelReset();
    map = IDENTITY;
    #12;
    checkSilent("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(3, "idle");

    $display("[TB] hold code 3 on identity map");
    note_in = 3'd3; note_valid = 1'b1;
    applyStimulus(40, "play3");

    $display("[TB] switch 3 -> 0 mid-tone");
    note_in = 3'd0;
    applyStimulus(20, "switch0");

    $display("[TB] duplicate-code map and missing code");
    map = DUPMAP; note_in = 3'd6;
    applyStimulus(30, "dup6");
    note_in = 3'd7;
    applyStimulus(6, "miss7");
    note_in = 3'd6;
    applyStimulus(10, "miss_to_play");

    $display("[TB] release and re-press");
    note_valid = 1'b0;
    applyStimulus(30, "release");
    note_valid = 1'b1;
    applyStimulus(20, "press");
    note_valid = 1'b0;
    applyStimulus(10, "release2");
    note_valid = 1'b1;
    applyStimulus(10, "repress");
    note_valid = 1'b0;
    applyStimulus(25, "release3");

    $display("[TB] asynchronous reset mid-tone");
    map = IDENTITY; note_in = 3'd4; note_valid = 1'b1;
    applyStimulus(30, "play4");
    #3;
    rst_n = 1'b0;
    #1;
    checkSilent("async_reset");
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkSilent("reset_edges");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(30, "after_reset");

    $display("[TB] randomized segments");
    for (int s = 0; s < 40; s++) begin
      if (s % 8 == 0) begin
        map = ($urandom_range(0, 2) == 0) ? IDENTITY : 24'($urandom());
      end
      note_in    = 3'($urandom_range(0, 7));
      note_valid = ($urandom_range(0, 3) != 0);
      applyStimulus($urandom_range(1, 30), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
